// File: rtl/cr16_writeback_pkg.sv
// cr16_pkg: constants shared by the CR16 writeback stage.
//   - PSR / ALU status bit positions
//   - 4-bit condition codes used by branches, jumps and Scond
//   - register-write buffer depth
package cr16_pkg;

  localparam int CARRY    = 0;
  localparam int LOW      = 1;
  localparam int FLAG     = 2;
  localparam int ZERO     = 3;
  localparam int NEGATIVE = 4;

  localparam int PSR_WIDTH = 5;

  localparam logic [3:0] CC_EQ    = 4'd0;
  localparam logic [3:0] CC_NE    = 4'd1;
  localparam logic [3:0] CC_CS    = 4'd2;
  localparam logic [3:0] CC_CC    = 4'd3;
  localparam logic [3:0] CC_HI    = 4'd4;
  localparam logic [3:0] CC_LS    = 4'd5;
  localparam logic [3:0] CC_GT    = 4'd6;
  localparam logic [3:0] CC_LE    = 4'd7;
  localparam logic [3:0] CC_FS    = 4'd8;
  localparam logic [3:0] CC_FC    = 4'd9;
  localparam logic [3:0] CC_LO    = 4'd10;
  localparam logic [3:0] CC_HS    = 4'd11;
  localparam logic [3:0] CC_LT    = 4'd12;
  localparam logic [3:0] CC_GE    = 4'd13;
  localparam logic [3:0] CC_UC    = 4'd14;
  localparam logic [3:0] CC_NEVER = 4'd15;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/cr16_writeback_if.sv
// cr16_writeback_if: ALU-result handshake and register-file write port.
//   master: ALU / register-file side (drives results and rf_ready)
//   slave : writeback stage (drives ready and the register-file write request)
interface cr16_writeback_if #(
  parameter int P_WIDTH      = 16,
  parameter int P_ADDR_WIDTH = 4
);
  logic                    valid;
  logic                    ready;
  logic [P_WIDTH-1:0]      result;
  logic [4:0]              status;
  logic [P_ADDR_WIDTH-1:0] dest;
  logic                    write_reg;
  logic                    write_psr;
  logic                    scond;
  logic [3:0]              scond_code;

  logic                    rf_we;
  logic                    rf_ready;
  logic [P_ADDR_WIDTH-1:0] rf_addr;
  logic [P_WIDTH-1:0]      rf_data;

  modport master (
    output valid, result, status, dest, write_reg, write_psr, scond, scond_code,
    output rf_ready,
    input  ready, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  valid, result, status, dest, write_reg, write_psr, scond, scond_code,
    input  rf_ready,
    output ready, rf_we, rf_addr, rf_data
  );
endinterface

// File: rtl/cr16_writeback_cond_eval.sv
// cr16_cond_eval: combinational CR16 condition-code evaluation.
//   code  : 4-bit condition code
//   psr   : processor status {N, Z, F, L, C}
//   taken : condition holds under psr
module cr16_cond_eval
  import cr16_pkg::*;
(
  input  logic [3:0]           code,
  input  logic [PSR_WIDTH-1:0] psr,
  output logic                 taken
);

  logic c, l, f, z, n;

  assign c = psr[CARRY];
  assign l = psr[LOW];
  assign f = psr[FLAG];
  assign z = psr[ZERO];
  assign n = psr[NEGATIVE];

  always_comb begin
    taken = 1'b0;
    unique case (code)
      CC_EQ:    taken = z;
      CC_NE:    taken = ~z;
      CC_CS:    taken = c;
      CC_CC:    taken = ~c;
      CC_HI:    taken = l;
      CC_LS:    taken = ~l;
      CC_GT:    taken = n;
      CC_LE:    taken = ~n;
      CC_FS:    taken = f;
      CC_FC:    taken = ~f;
      CC_LO:    taken = ~l & ~z;
      CC_HS:    taken = l | z;
      CC_LT:    taken = ~n & ~z;
      CC_GE:    taken = n | z;
      CC_UC:    taken = 1'b1;
      CC_NEVER: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cr16_writeback.sv
// cr16_writeback: writeback stage after the CR16 ALU.
//   clk, rst_n : clock (rising edge), async active-low reset
//   wb         : ALU result handshake in, register-file write request out
//   psr        : current processor status register
//   br_code    : condition to evaluate for branch/jump, br_taken = result
//   haz_addr   : source register to check, hazard = pending write to it
// Flags commit on acceptance; register writes queue in a 2-entry FIFO that
// drains whenever the register file is ready.
module cr16_writeback
  import cr16_pkg::*;
#(
  parameter int P_WIDTH      = 16,
  parameter int P_ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cr16_writeback_if.slave         wb,
  output logic [PSR_WIDTH-1:0]    psr,
  input  logic [3:0]              br_code,
  output logic                    br_taken,
  input  logic [P_ADDR_WIDTH-1:0] haz_addr,
  output logic                    hazard
);

  logic [P_ADDR_WIDTH-1:0] addr_q [BUF_DEPTH];
  logic [P_WIDTH-1:0]      data_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]    vld_q;
  logic                    head_q;
  logic                    tail_q;
  logic [1:0]              count_q;
  logic [PSR_WIDTH-1:0]    psr_q;

  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    scond_true;
  logic [P_WIDTH-1:0]      push_data;

  assign wb.ready   = (count_q != 2'(BUF_DEPTH));
  assign accept     = wb.valid & wb.ready;
  assign push       = accept & wb.write_reg;
  assign pop        = wb.rf_we & wb.rf_ready;

  assign wb.rf_we   = vld_q[head_q];
  assign wb.rf_addr = addr_q[head_q];
  assign wb.rf_data = data_q[head_q];
  assign psr        = psr_q;

  // Scond sees the flags as they were before this instruction's own update.
  cr16_cond_eval u_scond_eval (
    .code  (wb.scond_code),
    .psr   (psr_q),
    .taken (scond_true)
  );

  cr16_cond_eval u_branch_eval (
    .code  (br_code),
    .psr   (psr_q),
    .taken (br_taken)
  );

  assign push_data = wb.scond ? {{(P_WIDTH-1){1'b0}}, scond_true} : wb.result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      vld_q   <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      psr_q   <= '0;
    end else begin
      if (accept && wb.write_psr) begin
        psr_q <= wb.status;
      end
      // A push never targets the head slot while it is being popped: that
      // would need count==2, where push is blocked by ready.
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= ~head_q;
      end
      if (push) begin
        addr_q[tail_q] <= wb.dest;
        data_q[tail_q] <= push_data;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= ~tail_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == haz_addr)) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cr16_writeback.sv
module tb_cr16_writeback;

  logic       clk;
  logic       rst_n;
  logic [4:0] psr;
  logic [3:0] br_code;
  logic       br_taken;
  logic [3:0] haz_addr;
  logic       hazard;

  int checks;
  int errors;

  logic [4:0]  model_psr;
  logic [19:0] exp_q [$];

  cr16_writeback_if #(.P_WIDTH(16), .P_ADDR_WIDTH(4)) wb ();

  cr16_writeback #(.P_WIDTH(16), .P_ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb       (wb.slave),
    .psr      (psr),
    .br_code  (br_code),
    .br_taken (br_taken),
    .haz_addr (haz_addr),
    .hazard   (hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition table, bits {N,Z,F,L,C}.
  function automatic logic cond_ref(input logic [3:0] code, input logic [4:0] p);
    logic c, l, f, z, n;
    c = p[0]; l = p[1]; f = p[2]; z = p[3]; n = p[4];
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return f;
      4'd9:  return !f;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] dest, input logic [15:0] res, input logic [4:0] st,
                       input logic wreg, input logic wpsr, input logic sc, input logic [3:0] code);
    wb.valid      = 1'b1;
    wb.dest       = dest;
    wb.result     = res;
    wb.status     = st;
    wb.write_reg  = wreg;
    wb.write_psr  = wpsr;
    wb.scond      = sc;
    wb.scond_code = code;
  endtask

  // Model the effect of an acceptance happening at the next edge.
  task automatic record();
    logic [15:0] d;
    if (wb.write_reg) begin
      d = wb.scond ? {15'd0, cond_ref(wb.scond_code, model_psr)} : wb.result;
      exp_q.push_back({wb.dest, d});
    end
    if (wb.write_psr) model_psr = wb.status;
  endtask

  task automatic send(input logic [3:0] dest, input logic [15:0] res, input logic [4:0] st,
                      input logic wreg, input logic wpsr, input logic sc, input logic [3:0] code);
    bit acc;
    acc = 1'b0;
    drive(dest, res, st, wreg, wpsr, sc, code);
    for (int i = 0; i < 20; i++) begin
      if (wb.ready) begin
        acc = 1'b1;
        record();
      end
      step();
      if (acc) break;
    end
    wb.valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // One cycle of offering; valid drops afterwards.
  task automatic offer(input logic [3:0] dest, input logic [15:0] res, input logic [4:0] st,
                       input logic wreg, input logic wpsr, output bit acc);
    drive(dest, res, st, wreg, wpsr, 1'b0, 4'd0);
    acc = wb.ready;
    if (acc) record();
    step();
    wb.valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wb.rf_we) && n < 50) begin
      step();
      n++;
    end
    chk("drain_remaining", exp_q.size(), 32'd0);
  endtask

  // Drain occurs at the next rising edge; inputs only change just after edges.
  always @(negedge clk) begin
    logic [19:0] item;
    if (rst_n && wb.rf_we && wb.rf_ready) begin
      if (exp_q.size() == 0) begin
        chk("drain_unexpected", 32'd1, 32'd0);
      end else begin
        item = exp_q.pop_front();
        chk("rf_addr", {28'd0, wb.rf_addr}, {28'd0, item[19:16]});
        chk("rf_data", {16'd0, wb.rf_data}, {16'd0, item[15:0]});
      end
    end
  end

  initial begin
    logic [4:0] sweep_psr [4];
    bit acc;
    checks = 0;
    errors = 0;
    model_psr = 5'd0;
    rst_n = 1'b0;
    wb.valid = 1'b0; wb.result = '0; wb.status = '0; wb.dest = '0;
    wb.write_reg = 1'b0; wb.write_psr = 1'b0; wb.scond = 1'b0; wb.scond_code = '0;
    wb.rf_ready = 1'b0;
    br_code = 4'd0;
    haz_addr = 4'd0;

    step();
    step();
    chk("rst_rf_we",   {31'd0, wb.rf_we},   32'd0);
    chk("rst_psr",     {27'd0, psr},        32'd0);
    chk("rst_hazard",  {31'd0, hazard},     32'd0);
    chk("rst_ready",   {31'd0, wb.ready},   32'd1);
    chk("rst_rf_addr", {28'd0, wb.rf_addr}, 32'd0);
    chk("rst_rf_data", {16'd0, wb.rf_data}, 32'd0);
    rst_n = 1'b1;
    step();

    // ADD result 0 with Z set: flags and write visible one cycle later.
    wb.rf_ready = 1'b1;
    drive(4'd3, 16'h0000, 5'b01000, 1'b1, 1'b1, 1'b0, 4'd0);
    #1;
    chk("no_bypass_rf_we", {31'd0, wb.rf_we}, 32'd0);
    chk("no_bypass_psr",   {27'd0, psr},      32'd0);
    record();
    step();
    wb.valid = 1'b0;
    br_code = 4'd0;
    #1;
    chk("t1_psr",     {27'd0, psr},        {27'd0, 5'b01000});
    chk("t1_br_eq",   {31'd0, br_taken},   32'd1);
    chk("t1_rf_we",   {31'd0, wb.rf_we},   32'd1);
    chk("t1_rf_addr", {28'd0, wb.rf_addr}, 32'd3);
    wait_drain();

    // Backpressure: two writes fill the buffer, third waits.
    wb.rf_ready = 1'b0;
    send(4'd1, 16'h1111, 5'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    send(4'd2, 16'h2222, 5'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("t2_ready_full", {31'd0, wb.ready}, 32'd0);
    offer(4'd5, 16'h5555, 5'd0, 1'b1, 1'b0, acc);
    chk("t2_third_stalled", {31'd0, acc}, 32'd0);
    chk("t2_head_stable", {28'd0, wb.rf_addr}, 32'd1);
    haz_addr = 4'd2; #1;
    chk("t2_hazard_2", {31'd0, hazard}, 32'd1);
    haz_addr = 4'd1; #1;
    chk("t2_hazard_1", {31'd0, hazard}, 32'd1);
    haz_addr = 4'd5; #1;
    chk("t2_hazard_5", {31'd0, hazard}, 32'd0);
    wb.rf_ready = 1'b1;
    send(4'd5, 16'h5555, 5'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    wait_drain();
    chk("t2_hazard_empty", {31'd0, hazard}, 32'd0);

    // Scond uses pre-update flags.
    send(4'd0, 16'h0000, 5'b00010, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("t3_psr_l", {27'd0, psr}, {27'd0, 5'b00010});
    send(4'd7, 16'hbeef, 5'd0, 1'b1, 1'b0, 1'b1, 4'd4);
    send(4'd7, 16'hbeef, 5'd0, 1'b1, 1'b1, 1'b1, 4'd5);
    chk("t3_psr_cleared", {27'd0, psr}, 32'd0);
    wait_drain();

    // Condition sweep.
    sweep_psr[0] = 5'b00000;
    sweep_psr[1] = 5'b11111;
    sweep_psr[2] = 5'b01000;
    sweep_psr[3] = 5'b10000;
    for (int p = 0; p < 4; p++) begin
      send(4'd0, 16'h0000, sweep_psr[p], 1'b0, 1'b1, 1'b0, 4'd0);
      chk("sweep_psr", {27'd0, psr}, {27'd0, model_psr});
      for (int c = 0; c < 16; c++) begin
        br_code = 4'(c);
        #1;
        chk($sformatf("br_p%0d_c%0d", p, c), {31'd0, br_taken}, {31'd0, cond_ref(4'(c), model_psr)});
      end
    end

    // Compare-style instruction blocked behind a full buffer.
    wb.rf_ready = 1'b0;
    send(4'd4, 16'h4444, 5'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    send(4'd6, 16'h6666, 5'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    offer(4'd0, 16'h0000, 5'b10101, 1'b0, 1'b1, acc);
    chk("t5_cmp_stalled", {31'd0, acc}, 32'd0);
    chk("t5_psr_held", {27'd0, psr}, {27'd0, 5'b10000});
    wb.rf_ready = 1'b1;
    send(4'd0, 16'h0000, 5'b10101, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("t5_psr_new", {27'd0, psr}, {27'd0, 5'b10101});
    wait_drain();

    // Reset with two queued entries and all flags set.
    wb.rf_ready = 1'b0;
    send(4'd0, 16'h0000, 5'b11111, 1'b0, 1'b1, 1'b0, 4'd0);
    send(4'd8, 16'h8888, 5'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    send(4'd9, 16'h9999, 5'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    haz_addr = 4'd8; #1;
    chk("t6_psr_pre",    {27'd0, psr},      {27'd0, 5'b11111});
    chk("t6_hazard_pre", {31'd0, hazard},   32'd1);
    chk("t6_ready_pre",  {31'd0, wb.ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rf_we",  {31'd0, wb.rf_we}, 32'd0);
    chk("t6_rst_psr",    {27'd0, psr},      32'd0);
    chk("t6_rst_hazard", {31'd0, hazard},   32'd0);
    exp_q.delete();
    model_psr = 5'd0;
    step();
    rst_n = 1'b1;
    step();
    chk("t6_ready_post", {31'd0, wb.ready}, 32'd1);
    chk("t6_rf_we_post", {31'd0, wb.rf_we}, 32'd0);

    wb.rf_ready = 1'b1;
    wait_drain();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr16_writeback.md
# cr16_writeback

Writeback stage directly downstream of the CR16 ALU. Accepts each ALU result with its 5-bit status vector over a valid/ready handshake and commits flag updates to the Processor Status Register (PSR) on acceptance. Queues register-file writes in a 2-entry buffer drained under register-file backpressure. Also evaluates CR16 condition codes against the PSR for branch/jump decisions and Scond results, and flags read-after-write hazards on queued destinations.

## Interface
- P_WIDTH, 16, datapath width
- P_ADDR_WIDTH, 4, register-file address width
- I_CLK  in  1  sole clock, rising edge
- I_NRESET  in  1  reset, asynchronous, active-low
- I_VALID  in  1  ALU result valid
- O_READY  out  1  stage can accept (buffer not full)
- I_RESULT  in  P_WIDTH  ALU result
- I_STATUS  in  5  ALU status; bit 0 C, 1 L, 2 F, 3 Z, 4 N
- I_DEST  in  P_ADDR_WIDTH  destination register
- I_WRITE_REG  in  1  instruction writes a register
- I_WRITE_PSR  in  1  instruction updates flags
- I_SCOND  in  1  Scond: write condition result instead of I_RESULT
- I_SCOND_CODE  in  4  condition for Scond
- O_RF_WE  out  1  head entry valid, write request
- I_RF_READY  in  1  register file accepts write this cycle
- O_RF_ADDR  out  P_ADDR_WIDTH  head destination
- O_RF_DATA  out  P_WIDTH  head data
- O_PSR  out  5  current PSR
- I_BR_CODE  in  4  condition for branch/jump query
- O_BR_TAKEN  out  1  I_BR_CODE true under current PSR
- I_HAZ_ADDR  in  P_ADDR_WIDTH  source register to check
- O_HAZARD  out  1  I_HAZ_ADDR matches a queued valid entry

## Operation
- Accept = I_VALID & O_READY. O_READY = (count != 2), purely from state.
- On accept with I_WRITE_PSR: PSR <= I_STATUS. Without it, PSR holds.
- On accept with I_WRITE_REG: push {I_DEST, data}. Data = I_SCOND ? zero-extended cond(I_SCOND_CODE, PSR) : I_RESULT. Condition is evaluated on PSR before this accept's update.
- Accept with I_WRITE_REG=0 pushes nothing. PSR-only instructions (compare) never occupy the buffer.
- Drain = O_RF_WE & I_RF_READY: pop head.
- Push and pop in the same cycle: count unchanged, order preserved. Full buffer plus drain does not accept in that cycle because O_READY is already 0.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - 10 LO: !L&!Z
  - 11 HS: L|Z
  - 12 LT: !N&!Z
  - 13 GE: N|Z
  - 14 UC: 1
  - 15 never: 0
- O_HAZARD = OR over valid entries of (entry.addr == I_HAZ_ADDR).

## Timing
- Reset (async, I_NRESET=0): PSR=0, count=0, head/tail=0, O_RF_WE=0, O_HAZARD=0. O_READY=1 once count=0, but input is ignored while I_NRESET is low. O_RF_ADDR and O_RF_DATA are 0.
- Reset mid-operation discards queued writes and clears the PSR.
- PSR latency 1: flags from an accept at edge k are visible on O_PSR and O_BR_TAKEN after edge k.
- Register-write latency: earliest O_RF_WE is the cycle after accept; there is no combinational input-to-output bypass.
- O_BR_TAKEN and O_HAZARD are combinational from the PSR, buffer state and query inputs.
- Pointers are 1-bit and wrap 1→0. Count is 2 bits, range 0..2.
- O_RF_ADDR and O_RF_DATA are stable while O_RF_WE=1 and I_RF_READY=0.

## Structure
- Shared package cr16_pkg:
  - status index constants (CARRY=0, LOW=1, FLAG=2, ZERO=3, NEGATIVE=4)
  - 4-bit condition-code constants
  - buffer depth constant (2)
- Sub-module cr16_cond_eval, combinational: (code, psr) → true. It is instantiated twice, once for the branch query and once for Scond.

## Test plan
- Reset then ADD result 0x0000 with status 5'b01000, WRITE_PSR=1, WRITE_REG=1, dest 3, I_RF_READY=1 -> next cycle: O_PSR=01000, O_BR_TAKEN=1 for code 0, O_RF_WE=1 with addr 3 and data 0x0000.
- Hold I_RF_READY=0 and accept three writes (dest 1,2,5) -> third stalled: O_READY=0 after two. O_HAZARD=1 for addr 2, 0 for addr 5. Raise I_RF_READY -> writes in order 1,2,5.
- PSR=5'b00010 (L), Scond code 4 to dest 7 -> O_RF_DATA=0x0001. Code 5 -> 0x0000. Same-cycle WRITE_PSR status 0 does not affect the value written.
- Sweep all 16 codes against PSR values 00000, 11111, 01000, 10000 -> O_BR_TAKEN matches the table (e.g., LO with PSR=0 is 1, GE with PSR=01000 is 1, code 15 always 0).
- Compare-style accept (WRITE_REG=0, WRITE_PSR=1) while buffer full -> not accepted until O_READY=1. PSR changes only at acceptance.
- Assert I_NRESET low with 2 queued entries and PSR=11111 -> immediately O_RF_WE=0, O_PSR=0, O_HAZARD=0. After release, O_READY=1.
